// File: rtl/ifetch_thread_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : ifetch_thread_scheduler
// Purpose : Round-robin selection of one fetch thread per cycle, skipping
//           threads asleep on an icache miss.
// Revision: 1.0 - initial release
// ============================================================================
module ifetch_thread_scheduler #(
    parameter int THREADS = 4,
    parameter int TIDX_W  = $clog2(THREADS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [THREADS-1:0] ts_fetch_en,
    input  logic               ifd_cache_miss,
    input  logic [TIDX_W-1:0]  ifd_cache_miss_thread_idx,
    input  logic               ifd_near_miss,
    input  logic [THREADS-1:0] l2i_icache_wake_bitmap,
    input  logic               wb_rollback_en,
    input  logic [TIDX_W-1:0]  wb_rollback_thread_idx,
    input  logic               dt_update_itlb_en,
    input  logic               dt_invalidate_tlb_en,
    input  logic               dt_invalidate_tlb_all_en,
    input  logic               ocd_halt,
    output logic               sched_fetch_en,
    output logic [TIDX_W-1:0]  sched_thread_idx,
    output logic [THREADS-1:0] sched_thread_oh,
    output logic [THREADS-1:0] sched_wait_bitmap
);

    logic [THREADS-1:0] wait_bitmap;
    logic [TIDX_W-1:0]  rr_ptr;

    logic [THREADS-1:0] rollback_oh;
    logic [THREADS-1:0] miss_oh;
    logic [THREADS-1:0] sleep_set;
    logic [THREADS-1:0] eligible;
    logic               steal;
    logic               grant_found;
    logic [TIDX_W-1:0]  grant_idx;
    logic [TIDX_W-1:0]  cand;

    always_comb begin
        rollback_oh = '0;
        miss_oh     = '0;
        rollback_oh[wb_rollback_thread_idx]  = wb_rollback_en;
        miss_oh[ifd_cache_miss_thread_idx]   = 1'b1;
    end

    // A rollback on the missing thread squashes the fetch, so it must not sleep.
    assign sleep_set = (ifd_cache_miss && !ifd_near_miss &&
                        !rollback_oh[ifd_cache_miss_thread_idx]) ? miss_oh : '0;

    assign eligible = ts_fetch_en & ~wait_bitmap & ~rollback_oh;
    assign steal    = ocd_halt | dt_update_itlb_en | dt_invalidate_tlb_en |
                      dt_invalidate_tlb_all_en;

    // Scan from rr_ptr; index arithmetic wraps because THREADS is a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < THREADS; i++) begin
            cand = rr_ptr + TIDX_W'(i);
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        if (steal || reset) begin
            grant_found = 1'b0;
            grant_idx   = '0;
        end
    end

    always_comb begin
        sched_thread_oh            = '0;
        sched_thread_oh[grant_idx] = grant_found;
    end

    assign sched_fetch_en    = grant_found;
    assign sched_thread_idx  = grant_idx;
    assign sched_wait_bitmap = wait_bitmap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_bitmap <= '0;
            rr_ptr      <= '0;
        end else begin
            wait_bitmap <= (wait_bitmap | sleep_set) & ~l2i_icache_wake_bitmap;
            if (grant_found) begin
                rr_ptr <= grant_idx + TIDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_thread_scheduler.sv
`default_nettype none
// Testbench for ifetch_thread_scheduler: directed steps plus random traffic,
// checked against a behavioural model through an expectation queue.
module tb_ifetch_thread_scheduler;

    localparam int T = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [T-1:0] fe;
    logic         miss, near;
    logic [1:0]   miss_idx;
    logic [T-1:0] wake;
    logic         rb_en;
    logic [1:0]   rb_idx;
    logic         upd, inv, invall, halt;
    logic         sched_fetch_en;
    logic [1:0]   sched_thread_idx;
    logic [T-1:0] sched_thread_oh;
    logic [T-1:0] sched_wait_bitmap;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       en;
        logic [1:0] idx;
        logic [3:0] oh;
        logic [3:0] wbm;
    } exp_t;
    exp_t q[$];

    logic [3:0] m_wait;
    int         m_ptr;

    ifetch_thread_scheduler #(.THREADS(T), .TIDX_W(2)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .ts_fetch_en               (fe),
        .ifd_cache_miss            (miss),
        .ifd_cache_miss_thread_idx (miss_idx),
        .ifd_near_miss             (near),
        .l2i_icache_wake_bitmap    (wake),
        .wb_rollback_en            (rb_en),
        .wb_rollback_thread_idx    (rb_idx),
        .dt_update_itlb_en         (upd),
        .dt_invalidate_tlb_en      (inv),
        .dt_invalidate_tlb_all_en  (invall),
        .ocd_halt                  (halt),
        .sched_fetch_en            (sched_fetch_en),
        .sched_thread_idx          (sched_thread_idx),
        .sched_thread_oh           (sched_thread_oh),
        .sched_wait_bitmap         (sched_wait_bitmap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the model: predict outputs, compare at negedge, advance state.
    task automatic cycle();
        exp_t       e;
        exp_t       o;
        logic [3:0] rbm;
        logic [3:0] elig;
        logic [3:0] sleep;
        logic       g_en;
        int         g;
        g_en = 1'b0;
        g    = 0;
        rbm  = rb_en ? (4'b0001 << rb_idx) : 4'b0000;
        elig = fe & ~m_wait & ~rbm;
        for (int k = 0; k < T; k++) begin
            if (!g_en && elig[(m_ptr + k) % T]) begin
                g_en = 1'b1;
                g    = (m_ptr + k) % T;
            end
        end
        if (reset || halt || upd || inv || invall) begin
            g_en = 1'b0;
            g    = 0;
        end
        e.en  = g_en;
        e.idx = 2'(g);
        e.oh  = g_en ? (4'b0001 << g) : 4'b0000;
        e.wbm = reset ? 4'b0000 : m_wait;
        q.push_back(e);
        @(negedge clk);
        o = q.pop_front();
        chk("fetch_en", {7'b0, sched_fetch_en}, {7'b0, o.en});
        chk("thread_idx", {6'b0, sched_thread_idx}, {6'b0, o.idx});
        chk("thread_oh", {4'b0, sched_thread_oh}, {4'b0, o.oh});
        chk("wait_bitmap", {4'b0, sched_wait_bitmap}, {4'b0, o.wbm});
        sleep = (miss && !near && !(rb_en && rb_idx == miss_idx)) ? (4'b0001 << miss_idx) : 4'b0000;
        @(posedge clk);
        if (reset) begin
            m_wait = 4'b0000;
            m_ptr  = 0;
        end else begin
            m_wait = (m_wait | sleep) & ~wake;
            if (g_en) m_ptr = (g + 1) % T;
        end
        #1;
    endtask

    initial begin
        reset = 1'b1; fe = '0; miss = 1'b0; near = 1'b0; miss_idx = '0; wake = '0;
        rb_en = 1'b0; rb_idx = '0; upd = 1'b0; inv = 1'b0; invall = 1'b0; halt = 1'b0;
        m_wait = 4'b0000; m_ptr = 0;

        // Reset state with all threads requesting
        fe = 4'b1111;
        #2;
        chk("rst_fetch_en", {7'b0, sched_fetch_en}, 8'h00);
        chk("rst_oh", {4'b0, sched_thread_oh}, 8'h00);
        chk("rst_wait", {4'b0, sched_wait_bitmap}, 8'h00);
        cycle();
        cycle();
        reset = 1'b0;

        // Plain rotation 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rot_idx", {6'b0, sched_thread_idx}, 8'(i % T));
            cycle();
        end

        // Miss on thread 0, sleep 4 cycles, wake in the last
        fe = 4'b0001; miss = 1'b1; miss_idx = 2'd0;
        cycle();
        miss = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) wake = 4'b0001;
            #1;
            chk("sleep_en", {7'b0, sched_fetch_en}, 8'h00);
            chk("sleep_wait", {4'b0, sched_wait_bitmap}, 8'h01);
            cycle();
        end
        wake = 4'b0000;
        #1;
        chk("woken_idx", {6'b0, sched_thread_idx}, 8'h00);
        chk("woken_en", {7'b0, sched_fetch_en}, 8'h01);
        cycle();

        // Near miss does not sleep; same-cycle wake beats miss
        fe = 4'b1111; miss = 1'b1; near = 1'b1; miss_idx = 2'd2;
        cycle();
        near = 1'b0; miss_idx = 2'd1; wake = 4'b0010;
        #1;
        chk("near_wait", {4'b0, sched_wait_bitmap}, 8'h00);
        cycle();
        miss = 1'b0; wake = 4'b0000;
        #1;
        chk("wake_wins", {4'b0, sched_wait_bitmap}, 8'h00);
        for (int i = 0; i < 4; i++) cycle();

        // Rollback dead cycle with rr_ptr parked at 0
        fe = 4'b1000;
        cycle();
        fe = 4'b0101; rb_en = 1'b1; rb_idx = 2'd0;
        #1;
        chk("rb_idx", {6'b0, sched_thread_idx}, 8'h02);
        cycle();
        rb_en = 1'b0;
        #1;
        chk("rb_next", {6'b0, sched_thread_idx}, 8'h00);
        cycle();

        // Slot steals hold the rotation
        fe = 4'b1111; upd = 1'b1;
        #1;
        chk("itlb_steal", {7'b0, sched_fetch_en}, 8'h00);
        cycle();
        upd = 1'b0;
        #1;
        chk("itlb_resume", {6'b0, sched_thread_idx}, 8'h01);
        cycle();
        invall = 1'b1;
        #1;
        chk("flush_steal", {7'b0, sched_fetch_en}, 8'h00);
        cycle();
        invall = 1'b0;
        #1;
        chk("flush_resume", {6'b0, sched_thread_idx}, 8'h02);
        cycle();
        inv = 1'b1;
        cycle();
        inv = 1'b0;

        // Debug halt for 3 cycles
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halt_en", {7'b0, sched_fetch_en}, 8'h00);
            cycle();
        end
        halt = 1'b0;
        #1;
        chk("halt_resume", {6'b0, sched_thread_idx}, 8'h03);
        cycle();

        // Reset in the middle of a miss wait
        miss = 1'b1; miss_idx = 2'd1;
        cycle();
        miss = 1'b0;
        #1;
        chk("pre_rst_wait", {4'b0, sched_wait_bitmap}, 8'h02);
        reset = 1'b1;
        #1;
        chk("mid_rst_wait", {4'b0, sched_wait_bitmap}, 8'h00);
        chk("mid_rst_en", {7'b0, sched_fetch_en}, 8'h00);
        cycle();
        reset = 1'b0;
        #1;
        chk("post_rst_idx", {6'b0, sched_thread_idx}, 8'h00);
        chk("post_rst_en", {7'b0, sched_fetch_en}, 8'h01);
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            fe       = 4'($urandom);
            miss     = ($urandom_range(0, 2) == 0);
            near     = ($urandom_range(0, 3) == 0);
            miss_idx = 2'($urandom);
            wake     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            rb_en    = ($urandom_range(0, 3) == 0);
            rb_idx   = 2'($urandom);
            upd      = ($urandom_range(0, 11) == 0);
            inv      = ($urandom_range(0, 11) == 0);
            invall   = ($urandom_range(0, 11) == 0);
            halt     = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
